// File: rtl/scatter_hls_deadlock_report_unit.sv
// Deadlock report unit for the scatter kernel: latches the first detection with a timestamp,
// runs the token trace from the detecting process and keeps a sticky report until cleared.
module scatter_hls_deadlock_report_unit #(
  parameter int PROC_NUM      = 4,
  parameter int TS_W          = 32,
  parameter int TRACE_TIMEOUT = 256
) (
  input  logic                                                clock,
  input  logic                                                reset,
  input  logic [PROC_NUM-1:0]                                 dl_detect_vec,
  input  logic                                                status_clear,
  output logic                                                dl_detect_bcast,
  output logic [PROC_NUM-1:0]                                 origin_vec,
  output logic [PROC_NUM-1:0]                                 token_clear_vec,
  output logic                                                dl_valid,
  output logic [((PROC_NUM > 1) ? $clog2(PROC_NUM) : 1)-1:0]  dl_origin_id,
  output logic [PROC_NUM-1:0]                                 dl_proc_mask,
  output logic [TS_W-1:0]                                     dl_timestamp,
  output logic                                                dl_trace_done
);

  localparam int ID_W  = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1;
  localparam int CNT_W = (TRACE_TIMEOUT > 2) ? $clog2(TRACE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRACE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [TS_W-1:0]       ts_q, ts_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  bcast_q, bcast_d;
  logic [PROC_NUM-1:0]   origin_q, origin_d;
  logic                  valid_q, valid_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [PROC_NUM-1:0]   mask_q, mask_d;
  logic [TS_W-1:0]       tstamp_q, tstamp_d;
  logic                  done_q, done_d;
  logic [PROC_NUM-1:0]   token_clear_s;
  logic [ID_W-1:0]       det_idx_s;

  // Lowest set index wins when several units detect in the same cycle.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [PROC_NUM-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int k = PROC_NUM - 1; k >= 0; k--) begin
      if (v[k]) begin
        r = ID_W'(k);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Next-state, report update and combinational token_clear.
  always_comb begin
    state_d       = state_q;
    ts_d          = ts_q + TS_W'(1);
    cnt_d         = cnt_q;
    origin_d      = '0;
    valid_d       = valid_q;
    id_d          = id_q;
    mask_d        = mask_q;
    tstamp_d      = tstamp_q;
    done_d        = done_q;
    token_clear_s = '0;
    det_idx_s     = lowest_idx(dl_detect_vec);

    case (state_q)
      IDLE: begin
        if (|dl_detect_vec) begin
          state_d  = TRACE;
          origin_d = PROC_NUM'(1'b1) << det_idx_s;
          valid_d  = 1'b1;
          id_d     = det_idx_s;
          mask_d   = PROC_NUM'(1'b1) << det_idx_s;
          tstamp_d = ts_q;
          done_d   = 1'b0;
          cnt_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      TRACE: begin
        mask_d = mask_q | dl_detect_vec;
        if (status_clear) begin
          token_clear_s = '1;
          state_d       = IDLE;
          valid_d       = 1'b0;
          id_d          = '0;
          mask_d        = '0;
          tstamp_d      = '0;
          done_d        = 1'b0;
        // The origin's own detect bit is still up in the first TRACE cycle; only later ones count.
        end else if ((cnt_q != '0) && dl_detect_vec[id_q]) begin
          token_clear_s = PROC_NUM'(1'b1) << id_q;
          done_d        = 1'b1;
          state_d       = DONE;
        end else if (cnt_q == CNT_LAST) begin
          token_clear_s = '1;
          state_d       = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (status_clear) begin
          state_d  = IDLE;
          valid_d  = 1'b0;
          id_d     = '0;
          mask_d   = '0;
          tstamp_d = '0;
          done_d   = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    bcast_d = (state_d != IDLE);
  end

  // State and report registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ts_q     <= '0;
      cnt_q    <= '0;
      bcast_q  <= 1'b0;
      origin_q <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      mask_q   <= '0;
      tstamp_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_d;
      cnt_q    <= cnt_d;
      bcast_q  <= bcast_d;
      origin_q <= origin_d;
      valid_q  <= valid_d;
      id_q     <= id_d;
      mask_q   <= mask_d;
      tstamp_q <= tstamp_d;
      done_q   <= done_d;
    end
  end

  assign dl_detect_bcast = bcast_q;
  assign origin_vec      = origin_q;
  assign token_clear_vec = token_clear_s;
  assign dl_valid        = valid_q;
  assign dl_origin_id    = id_q;
  assign dl_proc_mask    = mask_q;
  assign dl_timestamp    = tstamp_q;
  assign dl_trace_done   = done_q;

endmodule

// File: tb/tb_scatter_hls_deadlock_report_unit.sv
// Directed bench for the deadlock report unit: a cycle model checked every negedge,
// plus hand-computed literal expectations at key points of each scenario.
module tb_scatter_hls_deadlock_report_unit;

  localparam int P  = 4;
  localparam int TW = 4;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [P-1:0]  dl_detect_vec = '0;
  logic          status_clear = 1'b0;
  logic          dl_detect_bcast;
  logic [P-1:0]  origin_vec;
  logic [P-1:0]  token_clear_vec;
  logic          dl_valid;
  logic [1:0]    dl_origin_id;
  logic [P-1:0]  dl_proc_mask;
  logic [TW-1:0] dl_timestamp;
  logic          dl_trace_done;

  scatter_hls_deadlock_report_unit #(.PROC_NUM(P), .TS_W(TW), .TRACE_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .dl_detect_vec(dl_detect_vec), .status_clear(status_clear),
    .dl_detect_bcast(dl_detect_bcast), .origin_vec(origin_vec), .token_clear_vec(token_clear_vec),
    .dl_valid(dl_valid), .dl_origin_id(dl_origin_id), .dl_proc_mask(dl_proc_mask),
    .dl_timestamp(dl_timestamp), .dl_trace_done(dl_trace_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  logic chk_en = 1'b0;

  // Model: phase 0 = no report, 1 = tracing, 2 = report frozen; age = TRACE cycles elapsed.
  int            m_phase;
  int            m_age;
  logic [P-1:0]  m_origin;
  logic [P-1:0]  m_mask;
  logic [1:0]    m_id;
  logic [TW-1:0] m_ts;
  logic [TW-1:0] m_tstamp;
  logic          m_valid;
  logic          m_done;

  function automatic int first_set(input logic [P-1:0] v);
    for (int k = 0; k < P; k++) if (v[k]) return k;
    return 0;
  endfunction

  function automatic logic [P-1:0] exp_tc();
    logic [P-1:0] one;
    one = 4'b0001;
    if (m_phase == 1) begin
      if (status_clear) return 4'b1111;
      if (m_age > 0 && dl_detect_vec[m_id]) return one << m_id;
      if (m_age == TO - 1) return 4'b1111;
    end
    return 4'b0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_phase <= 0; m_age <= 0; m_origin <= '0; m_mask <= '0; m_id <= '0;
      m_ts <= '0; m_tstamp <= '0; m_valid <= 1'b0; m_done <= 1'b0;
    end else begin
      m_origin <= '0;
      m_ts     <= m_ts + 4'd1;
      if (m_phase == 0) begin
        if (dl_detect_vec != 4'b0000) begin
          m_phase  <= 1;
          m_age    <= 0;
          m_valid  <= 1'b1;
          m_done   <= 1'b0;
          m_id     <= 2'(first_set(dl_detect_vec));
          m_mask   <= 4'b0001 << first_set(dl_detect_vec);
          m_origin <= 4'b0001 << first_set(dl_detect_vec);
          m_tstamp <= m_ts;
        end
      end else if (m_phase == 1 && status_clear) begin
        m_phase <= 0; m_valid <= 1'b0; m_done <= 1'b0; m_id <= '0; m_mask <= '0; m_tstamp <= '0;
      end else if (m_phase == 1) begin
        m_mask <= m_mask | dl_detect_vec;
        if (m_age > 0 && dl_detect_vec[m_id]) begin
          m_done  <= 1'b1;
          m_phase <= 2;
        end else if (m_age == TO - 1) begin
          m_phase <= 2;
        end else begin
          m_age <= m_age + 1;
        end
      end else if (m_phase == 2 && status_clear) begin
        m_phase <= 0; m_valid <= 1'b0; m_done <= 1'b0; m_id <= '0; m_mask <= '0; m_tstamp <= '0;
      end
    end
  end

  always @(negedge clock) begin
    if (reset && chk_en) begin
      chk("m_bcast",  dl_detect_bcast, m_phase != 0);
      chk("m_origin", origin_vec,      m_origin);
      chk("m_tclear", token_clear_vec, exp_tc());
      chk("m_valid",  dl_valid,        m_valid);
      chk("m_id",     dl_origin_id,    m_id);
      chk("m_mask",   dl_proc_mask,    m_mask);
      chk("m_tstamp", dl_timestamp,    m_tstamp);
      chk("m_done",   dl_trace_done,   m_done);
    end
  end

  task automatic cyc(input logic [P-1:0] v, input logic c);
    dl_detect_vec = v;
    status_clear  = c;
    @(posedge clock);
    #1;
    cyc_cnt++;
  endtask

  task automatic cyc_tc(input logic [P-1:0] v, input logic c, input logic [P-1:0] e, input string name);
    dl_detect_vec = v;
    status_clear  = c;
    #2;
    chk(name, token_clear_vec, e);
    @(posedge clock);
    #1;
    cyc_cnt++;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", dl_valid, 1'b0);
    chk("rst_bcast", dl_detect_bcast, 1'b0);
    chk("rst_mask", dl_proc_mask, 4'b0000);
    chk("rst_tstamp", dl_timestamp, 4'd0);
    reset   = 1'b1;
    chk_en  = 1'b1;
    cyc_cnt = 0;

    // Detect by process 2 at ts=10, then trace with bits 3,0 and return on bit 2.
    repeat (10) cyc(4'b0000, 1'b0);
    cyc(4'b0100, 1'b0);
    chk("t1_origin", origin_vec, 4'b0100);
    chk("t1_id", dl_origin_id, 2'd2);
    chk("t1_ts", dl_timestamp, 4'd10);
    chk("t1_bcast", dl_detect_bcast, 1'b1);
    cyc(4'b1000, 1'b0);
    chk("t1_origin_gone", origin_vec, 4'b0000);
    cyc(4'b0001, 1'b0);
    cyc_tc(4'b0100, 1'b0, 4'b0100, "t2_tc_return");
    chk("t2_mask", dl_proc_mask, 4'b1101);
    chk("t2_done", dl_trace_done, 1'b1);

    // Clear from DONE.
    cyc(4'b0000, 1'b1);
    chk("t5_valid", dl_valid, 1'b0);
    chk("t5_mask", dl_proc_mask, 4'b0000);
    chk("t5_bcast", dl_detect_bcast, 1'b0);

    // Simultaneous detect, then timeout with a bit-3 pulse along the way.
    cyc(4'b1010, 1'b0);
    chk("t3_id", dl_origin_id, 2'd1);
    chk("t3_mask", dl_proc_mask, 4'b0010);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    cyc(4'b1000, 1'b0);
    repeat (4) cyc(4'b0000, 1'b0);
    cyc_tc(4'b0000, 1'b0, 4'b1111, "t4_tc_timeout");
    chk("t4_done", dl_trace_done, 1'b0);
    chk("t4_valid", dl_valid, 1'b1);
    chk("t4_mask", dl_proc_mask, 4'b1010);
    cyc(4'b1111, 1'b0);
    chk("t4_mask_held", dl_proc_mask, 4'b1010);
    cyc(4'b0000, 1'b1);

    // Clear mid-TRACE; the detect in the clearing cycle is dropped.
    cyc(4'b0001, 1'b0);
    cyc(4'b0000, 1'b0);
    cyc_tc(4'b0010, 1'b1, 4'b1111, "t5_tc_clear");
    chk("t5b_valid", dl_valid, 1'b0);
    chk("t5b_bcast", dl_detect_bcast, 1'b0);
    cyc(4'b0000, 1'b1);
    chk("t5c_idle_clear", dl_valid, 1'b0);
    cyc(4'b0100, 1'b1);
    chk("t5d_valid", dl_valid, 1'b1);
    chk("t5d_id", dl_origin_id, 2'd2);
    cyc(4'b0000, 1'b0);
    cyc(4'b0100, 1'b0);
    chk("t5d_done", dl_trace_done, 1'b1);
    cyc(4'b0000, 1'b1);

    // Timestamp around the wrap.
    while ((cyc_cnt % 16) != 15) cyc(4'b0000, 1'b0);
    cyc(4'b0001, 1'b0);
    chk("t6_ts15", dl_timestamp, 4'd15);
    cyc(4'b0000, 1'b1);
    while ((cyc_cnt % 16) != 0) cyc(4'b0000, 1'b0);
    cyc(4'b0010, 1'b0);
    chk("t6_ts0", dl_timestamp, 4'd0);
    chk("t6_id", dl_origin_id, 2'd1);

    // Asynchronous reset mid-TRACE.
    cyc(4'b0000, 1'b0);
    #2;
    reset = 1'b0;
    dl_detect_vec = 4'b0010;
    #1;
    chk("ar_bcast", dl_detect_bcast, 1'b0);
    chk("ar_valid", dl_valid, 1'b0);
    chk("ar_mask", dl_proc_mask, 4'b0000);
    chk("ar_tclear", token_clear_vec, 4'b0000);
    chk("ar_ts", dl_timestamp, 4'd0);
    chk("ar_origin", origin_vec, 4'b0000);
    dl_detect_vec = 4'b0000;
    @(posedge clock);
    #1;
    reset   = 1'b1;
    cyc_cnt = 0;
    repeat (3) cyc(4'b0000, 1'b0);
    cyc(4'b1000, 1'b0);
    chk("post_rst_ts", dl_timestamp, 4'd3);
    chk("post_rst_id", dl_origin_id, 2'd3);
    cyc(4'b0000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
